// File: rtl/mul8_seq_pkg.sv
// mul8_seq_pkg: shared constants for the sequential 8x8 multiplier.
//   - state_e : FSM state encoding (IDLE, PP0..PP3), 3 bits
//   - widths of operands, sub-multiplier and product
//   - fa()    : full-adder cell used by the array multiplier
package mul8_seq_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PP0  = 3'd1,
    ST_PP1  = 3'd2,
    ST_PP2  = 3'd3,
    ST_PP3  = 3'd4
  } state_e;

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/mul8_seq_mul4x4.sv
// mul4x4: combinational 4x4 unsigned array multiplier built from full-adder
// cells arranged as ripple rows.
//   x  [3:0] in  : multiplicand nibble
//   y  [3:0] in  : multiplier nibble
//   pp [7:0] out : x*y
module mul4x4
  import mul8_seq_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] pp
);

  // Array reduction: row 0 seeds the sum, each later row i is added into
  // bits [i+3:i] through a chain of four full adders, carry landing in bit i+4.
  always_comb begin
    logic [7:0] s;
    logic       c;
    logic [1:0] r;
    s = {4'b0000, x & {4{y[0]}}};
    c = 1'b0;
    r = 2'b00;
    for (int i = 1; i < 4; i++) begin
      c = 1'b0;
      for (int j = 0; j < 4; j++) begin
        r        = fa(s[i+j], x[j] & y[i], c);
        s[i+j]   = r[0];
        c        = r[1];
      end
      s[i+4] = c;
    end
    pp = s;
  end

endmodule

// File: rtl/mul8_seq.sv
// mul8_seq: 8x8 unsigned multiplier that time-shares one 4x4 multiplier over
// four cycles (one nibble partial product per cycle).
//   clk   in      : clock, rising edge
//   rst   in      : synchronous active-high reset
//   start in      : request a multiply (only honoured while idle)
//   a, b  in  [7:0] : operands, latched when start is accepted
//   busy  out     : high while a multiply is in progress
//   done  out     : one-cycle pulse when p carries a new result
//   p     out [15:0]: registered product, held until next completion/reset
module mul8_seq
  import mul8_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] p_q, p_d;
  logic        done_q, done_d;

  logic [3:0]  x_s, y_s;
  logic [7:0]  pp_s;
  logic [15:0] part_s;

  mul4x4 u_mul4x4 (
    .x  (x_s),
    .y  (y_s),
    .pp (pp_s)
  );

  // Nibble selection and shift of the partial product for the current state.
  always_comb begin
    x_s    = 4'h0;
    y_s    = 4'h0;
    part_s = 16'h0000;
    case (state_q)
      ST_PP0: begin
        x_s    = a_q[3:0];
        y_s    = b_q[3:0];
        part_s = {8'h00, pp_s};
      end
      ST_PP1: begin
        x_s    = a_q[7:4];
        y_s    = b_q[3:0];
        part_s = {4'h0, pp_s, 4'h0};
      end
      ST_PP2: begin
        x_s    = a_q[3:0];
        y_s    = b_q[7:4];
        part_s = {4'h0, pp_s, 4'h0};
      end
      ST_PP3: begin
        x_s    = a_q[7:4];
        y_s    = b_q[7:4];
        part_s = {pp_s, 8'h00};
      end
      default: begin
        x_s    = 4'h0;
        y_s    = 4'h0;
        part_s = 16'h0000;
      end
    endcase
  end

  // Next-state, accumulation and result load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PP0;
          a_d     = a;
          b_d     = b;
          acc_d   = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PP0: begin
        acc_d   = acc_q + part_s;
        state_d = ST_PP1;
      end
      ST_PP1: begin
        acc_d   = acc_q + part_s;
        state_d = ST_PP2;
      end
      ST_PP2: begin
        acc_d   = acc_q + part_s;
        state_d = ST_PP3;
      end
      ST_PP3: begin
        // Final partial goes straight into p; the accumulator is not updated.
        p_d     = acc_q + part_s;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
      p_q     <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: directed scenarios plus random traffic,
// compared each cycle against a latency/product reference model.
module tb_mul8_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int checks;
  int errors;
  int done_cnt;

  // Reference model: cycles remaining until result, pending product, outputs.
  int          m_cnt;
  logic [15:0] m_pend;
  logic [15:0] m_p;
  logic        m_done;

  mul8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic cycle(input logic r, input logic s, input logic [7:0] av, input logic [7:0] bv);
    rst   = r;
    start = s;
    a     = av;
    b     = bv;
    @(posedge clk);
    if (r) begin
      m_cnt  = 0;
      m_p    = 16'h0000;
      m_done = 1'b0;
    end else if (m_cnt == 0) begin
      m_done = 1'b0;
      if (s) begin
        m_cnt  = 4;
        m_pend = {8'h00, av} * {8'h00, bv};
      end
    end else begin
      m_cnt  = m_cnt - 1;
      m_done = (m_cnt == 0);
      if (m_cnt == 0) m_p = m_pend;
    end
    #1;
    check_eq("busy", {15'd0, busy}, {15'd0, (m_cnt != 0)});
    check_eq("done", {15'd0, done}, {15'd0, m_done});
    check_eq("p", p, m_p);
    if (done) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    m_cnt    = 0;
    m_pend   = 16'h0000;
    m_p      = 16'h0000;
    m_done   = 1'b0;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;

    // Reset, with start asserted to show reset wins.
    cycle(1'b1, 1'b1, 8'h55, 8'h66);
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("rst_p", p, 16'h0000);
    check_eq("rst_busy", {15'd0, busy}, 16'h0000);

    // Max operands.
    done_cnt = 0;
    cycle(1'b0, 1'b1, 8'hFF, 8'hFF);
    idle(3);
    check_eq("max_busy_k3", {15'd0, busy}, 16'h0001);
    idle(1);
    check_eq("max_p", p, 16'hFE01);
    check_eq("max_done", {15'd0, done}, 16'h0001);
    idle(2);
    check_eq("max_done_cnt", done_cnt[15:0], 16'h0001);
    check_eq("max_p_hold", p, 16'hFE01);

    // Mid-range operands.
    cycle(1'b0, 1'b1, 8'h12, 8'h34);
    idle(4);
    check_eq("mid_p", p, 16'h03A8);

    // Zero operand.
    done_cnt = 0;
    cycle(1'b0, 1'b1, 8'h00, 8'hAB);
    idle(4);
    check_eq("zero_p", p, 16'h0000);
    check_eq("zero_done", done_cnt[15:0], 16'h0001);

    // Start while busy is ignored; operand changes have no effect.
    done_cnt = 0;
    cycle(1'b0, 1'b1, 8'h0F, 8'h0F);
    cycle(1'b0, 1'b0, 8'hF0, 8'hF0);
    cycle(1'b0, 1'b1, 8'hF0, 8'hF0);
    cycle(1'b0, 1'b0, 8'hF0, 8'hF0);
    idle(1);
    check_eq("busy_start_p", p, 16'h00E1);
    idle(6);
    check_eq("busy_start_dones", done_cnt[15:0], 16'h0001);

    // Back-to-back with start held high.
    done_cnt = 0;
    cycle(1'b0, 1'b1, 8'h10, 8'h10);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h03, 8'h05);
    cycle(1'b0, 1'b1, 8'h03, 8'h05);
    check_eq("b2b_p0", p, 16'h0100);
    check_eq("b2b_done0", {15'd0, done}, 16'h0001);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h03, 8'h05);
    cycle(1'b0, 1'b0, 8'h03, 8'h05);
    check_eq("b2b_p1", p, 16'h000F);
    check_eq("b2b_done1", {15'd0, done}, 16'h0001);
    idle(2);

    // Reset during PP2 aborts the operation.
    done_cnt = 0;
    cycle(1'b0, 1'b1, 8'hFF, 8'h02);
    idle(2);
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("abort_busy", {15'd0, busy}, 16'h0000);
    check_eq("abort_done", {15'd0, done}, 16'h0000);
    check_eq("abort_p", p, 16'h0000);
    idle(6);
    check_eq("abort_no_done", done_cnt[15:0], 16'h0000);

    // First start after reset is accepted.
    cycle(1'b0, 1'b1, 8'h07, 8'h09);
    idle(4);
    check_eq("post_rst_p", p, 16'h003F);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
            8'($urandom), 8'($urandom));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul8_seq.md
MUL8_SEQ -- requirements
Module: mul8_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits and the sub-multiplier width at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  8  unsigned multiplicand; sampled when start is accepted.
REQ-006 b  input  8  unsigned multiplier; sampled when start is accepted.
REQ-007 busy  output  1  high while a multiply is in progress (state not IDLE).
REQ-008 done  output  1  one-cycle pulse marking a new valid result on p.
REQ-009 p  output  16  unsigned product a*b; registered; holds until the next completion or reset.

Function
REQ-010 The block SHALL compute the 8x8 unsigned product using exactly one 4x4 combinational multiplier instance, time-shared over four cycles.
REQ-011 The FSM SHALL have states IDLE, PP0, PP1, PP2 and PP3.
REQ-012 The PPn states SHALL select these partials:
- PP0: aL*bL, shift 0
- PP1: aH*bL, shift 4
- PP2: aL*bH, shift 4
- PP3: aH*bH, shift 8
(aL/aH, bL/bH are the low/high nibbles of the latched operands.)
REQ-013 On each edge taken in PP0..PP2, the 16-bit accumulator SHALL add the current partial, zero-extended and shifted; on entry from IDLE it SHALL be cleared.
REQ-014 The accumulator SHALL be 16 bits and no carry beyond bit 15 SHALL occur; none is possible for unsigned 8x8 operands.
REQ-015 The FSM SHALL make these transitions:
- IDLE->PP0 on start=1 at an edge, latching a and b.
- PP0->PP1->PP2->PP3 unconditionally.
- PP3->IDLE unconditionally.
REQ-016 On the PP3->IDLE edge, p SHALL load accumulator + (aH*bH << 8) and done SHALL go high for exactly that following cycle.
REQ-017 Latency: if start is accepted at edge k, done and the new p SHALL be visible after edge k+4.
REQ-018 busy SHALL be high after edges k..k+3 and low once the FSM returns to IDLE.
REQ-019 start while busy=1 SHALL be ignored, with no queuing; operand changes while busy SHALL NOT affect the result.
REQ-020 start sampled in the cycle done is high SHALL be accepted (FSM already in IDLE), giving back-to-back throughput of one result per 5 cycles.
REQ-021 p SHALL NOT change except on a completion edge or reset.

Reset
REQ-022 rst=1 at an edge SHALL force state=IDLE, accumulator=0, latched operands=0, p=0, done=0 and busy=0, overriding start.
REQ-023 Reset mid-operation SHALL abort the multiply: no done pulse is produced for it and p reads 0.
REQ-024 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-025 State encodings (IDLE..PP3, 3 bits) SHALL live in the shared multiplier constants package/header used by the arithmetic blocks.
REQ-026 The 4x4 partial product SHALL come from a single sub-module mul4x4: a combinational 4x4 unsigned array multiplier built from full-adder cells, 8-bit output.
REQ-027 Nibble select muxing, shifting, accumulation and the FSM SHALL reside in mul8_seq.

Verification
REQ-028 Max operands: start with a=0xFF, b=0xFF -> busy high 4 cycles, then done pulse once and p=0xFE01.
REQ-029 Mid-range operands: a=0x12, b=0x34 -> p=0x03A8 at k+4.
REQ-030 Zero operand: a=0x00, b=0xAB -> p=0x0000 with a done pulse.
REQ-031 Start while busy: start a=0x0F, b=0x0F, then pulse start with a=0xF0, b=0xF0 at k+2 -> single done, p=0x00E1, no second done.
REQ-032 Back-to-back: hold start high continuously with a=0x10, b=0x10 then a=0x03, b=0x05 -> done at k+4 (p=0x0100) and k+9 (p=0x000F).
REQ-033 Reset mid-operation: assert rst in PP2 of a=0xFF, b=0x02 -> next cycle busy=0, done=0, p=0, and no later done pulse.
